// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame geometry and line levels for the UART transmitter.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_e;
   localparam int   UART_DATA_BITS            = 8;
   localparam int   UART_DEFAULT_CLKS_PER_BIT = 868;
   localparam logic LINE_IDLE                 = 1'b1;
   localparam logic LINE_START                = 1'b0;
   localparam logic LINE_STOP                 = 1'b1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter that pulses BitDone on the last clock of each serial bit.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic Restart,
   output logic BitDone
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   logic [CNT_W-1:0] baudCnt;
   assign BitDone = Run && (baudCnt == CNT_W'(CLKS_PER_BIT - 1));
   always_ff @(posedge Clk) begin
      if (Reset || Restart || !Run || BitDone) baudCnt <= '0;
      else baudCnt <= baudCnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter with request/load handshake.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [UART_DATA_BITS-1:0] TxData,
   input  logic                      RequestToSend,
   output logic                      DataLoaded,
   output logic                      TxBusy,
   output logic                      TxSerial
);
   localparam logic LAST_STOP = (STOP_BITS == 2);
   txState_e                  state, stateNext;
   logic [UART_DATA_BITS-1:0] shiftReg, shiftNext;
   logic [2:0]                dataCnt, dataCntNext;
   logic                      stopCnt, stopCntNext;
   logic                      bitDone, captureOk, load, lineNext, parityLine;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) bitTimer (
      .Clk     (Clk),
      .Reset   (Reset),
      .Run     (state != IDLE),
      .Restart (load),
      .BitDone (bitDone)
   );

`ifdef UART_TX_PARITY_EN
   logic parityBit, parityNext;
   assign parityNext = load ? ^TxData : parityBit;
   assign parityLine = parityNext;
   always_ff @(posedge Clk) begin
      if (Reset) parityBit <= 1'b0;
      else parityBit <= parityNext;
   end
`else
   assign parityLine = LINE_STOP;
`endif

   always_comb begin
      stateNext   = state;
      shiftNext   = shiftReg;
      dataCntNext = dataCnt;
      stopCntNext = stopCnt;
      captureOk   = 1'b0;
      case (state)
         IDLE: captureOk = 1'b1;
         START: if (bitDone) begin
            stateNext   = DATA;
            dataCntNext = 3'd0;
         end
         DATA: if (bitDone) begin
            shiftNext   = shiftReg >> 1;
            dataCntNext = dataCnt + 3'd1;
            if (dataCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               stateNext = PARITY;
`else
               stateNext = STOP;
`endif
               stopCntNext = 1'b0;
            end
         end
         PARITY: if (bitDone) begin
            stateNext   = STOP;
            stopCntNext = 1'b0;
         end
         STOP: if (bitDone) begin
            if (stopCnt == LAST_STOP) begin
               stateNext = IDLE;
               captureOk = 1'b1;
            end else stopCntNext = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
      // A capture in the final stop cycle chains straight into the next start bit
      load = captureOk && RequestToSend && !Reset;
      if (load) begin
         stateNext = START;
         shiftNext = TxData;
      end
      lineNext = (stateNext == START)  ? LINE_START :
                 (stateNext == DATA)   ? shiftNext[0] :
                 (stateNext == PARITY) ? parityLine :
                 (stateNext == IDLE)   ? LINE_IDLE : LINE_STOP;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         shiftReg <= '0;
         dataCnt  <= '0;
         stopCnt  <= 1'b0;
         TxSerial <= LINE_IDLE;
      end else begin
         state    <= stateNext;
         shiftReg <= shiftNext;
         dataCnt  <= dataCntNext;
         stopCnt  <= stopCntNext;
         TxSerial <= lineNext;
      end
   end

   assign DataLoaded = load;
   assign TxBusy     = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of framing, handshake, back-to-back and reset behaviour.
module tb_uart_tx_serializer;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL1 = (9 + 1 + PAR) * CPB;
   localparam int FL2 = (9 + 2 + PAR) * CPB;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] TxData = 8'h00;
   logic       req1 = 1'b0, req2 = 1'b0;
   logic       dl1, busy1, ser1, dl2, busy2, ser2;
   int         tests = 0, fails = 0;

   always #5 Clk = ~Clk;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .TxData(TxData), .RequestToSend(req1),
      .DataLoaded(dl1), .TxBusy(busy1), .TxSerial(ser1)
   );
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .TxData(TxData), .RequestToSend(req2),
      .DataLoaded(dl2), .TxBusy(busy2), .TxSerial(ser2)
   );

   // Expected line level k cycles after the capture cycle
   function automatic logic expLine(input logic [7:0] d, input int k);
      int idx;
      if (k < 1) return 1'b1;
      idx = (k - 1) / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (PAR == 1 && idx == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic test_reset();
      Reset = 1'b1; req1 = 1'b1; TxData = 8'h55;
      @(posedge Clk); #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         tests++; if (ser1 !== 1'b1) begin fails++; $display("FAIL reset_ser c=%0d got %b exp 1", c, ser1); end
         tests++; if (dl1 !== 1'b0) begin fails++; $display("FAIL reset_dl c=%0d got %b exp 0", c, dl1); end
         tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy c=%0d got %b exp 0", c, busy1); end
         @(posedge Clk); #1;
      end
      Reset = 1'b0;
      @(negedge Clk);
      tests++; if (dl1 !== 1'b1) begin fails++; $display("FAIL reset_first_dl got %b exp 1", dl1); end
      @(posedge Clk); #1;
      req1 = 1'b0;
      repeat (FL1 + 4) begin @(posedge Clk); #1; end
      @(negedge Clk);
      tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_drain_busy got %b exp 0", busy1); end
      @(posedge Clk); #1;
   endtask

   task automatic test_frame(input logic [7:0] d);
      TxData = d; req1 = 1'b1;
      @(negedge Clk);
      tests++; if (dl1 !== 1'b1) begin fails++; $display("FAIL frame_%02h_dl0 got %b exp 1", d, dl1); end
      tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL frame_%02h_busy0 got %b exp 0", d, busy1); end
      @(posedge Clk); #1;
      req1 = 1'b0; TxData = ~d;
      for (int k = 1; k <= FL1 + 4; k++) begin
         @(negedge Clk);
         tests++; if (ser1 !== expLine(d, k)) begin fails++; $display("FAIL frame_%02h_ser k=%0d got %b exp %b", d, k, ser1, expLine(d, k)); end
         tests++; if (busy1 !== (k <= FL1)) begin fails++; $display("FAIL frame_%02h_busy k=%0d got %b exp %b", d, k, busy1, k <= FL1); end
         tests++; if (dl1 !== 1'b0) begin fails++; $display("FAIL frame_%02h_dl k=%0d got %b exp 0", d, k, dl1); end
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      TxData = 8'h00; req1 = 1'b1;
      @(negedge Clk);
      tests++; if (dl1 !== 1'b1) begin fails++; $display("FAIL b2b_dl0 got %b exp 1", dl1); end
      @(posedge Clk); #1;
      TxData = 8'hFF;
      for (int k = 1; k <= FL1; k++) begin
         @(negedge Clk);
         tests++; if (ser1 !== expLine(8'h00, k)) begin fails++; $display("FAIL b2b_a_ser k=%0d got %b exp %b", k, ser1, expLine(8'h00, k)); end
         tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL b2b_a_busy k=%0d got %b exp 1", k, busy1); end
         tests++; if (dl1 !== (k == FL1)) begin fails++; $display("FAIL b2b_a_dl k=%0d got %b exp %b", k, dl1, k == FL1); end
         @(posedge Clk); #1;
         if (k == FL1) req1 = 1'b0;
      end
      for (int k = 1; k <= FL1 + 4; k++) begin
         @(negedge Clk);
         tests++; if (ser1 !== expLine(8'hFF, k)) begin fails++; $display("FAIL b2b_b_ser k=%0d got %b exp %b", k, ser1, expLine(8'hFF, k)); end
         tests++; if (busy1 !== (k <= FL1)) begin fails++; $display("FAIL b2b_b_busy k=%0d got %b exp %b", k, busy1, k <= FL1); end
         tests++; if (dl1 !== 1'b0) begin fails++; $display("FAIL b2b_b_dl k=%0d got %b exp 0", k, dl1); end
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_reset_mid_frame();
      TxData = 8'h3C; req1 = 1'b1;
      @(negedge Clk);
      tests++; if (dl1 !== 1'b1) begin fails++; $display("FAIL mid_dl0 got %b exp 1", dl1); end
      @(posedge Clk); #1;
      req1 = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge Clk);
         tests++; if (ser1 !== expLine(8'h3C, k)) begin fails++; $display("FAIL mid_ser k=%0d got %b exp %b", k, ser1, expLine(8'h3C, k)); end
         @(posedge Clk); #1;
      end
      Reset = 1'b1; req1 = 1'b1;
      @(negedge Clk);
      tests++; if (dl1 !== 1'b0) begin fails++; $display("FAIL mid_dl_in_reset got %b exp 0", dl1); end
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      tests++; if (ser1 !== 1'b1) begin fails++; $display("FAIL mid_ser_after got %b exp 1", ser1); end
      tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL mid_busy_after got %b exp 0", busy1); end
      tests++; if (dl1 !== 1'b1) begin fails++; $display("FAIL mid_dl_restart got %b exp 1", dl1); end
      @(posedge Clk); #1;
      req1 = 1'b0;
      for (int k = 1; k <= FL1 + 4; k++) begin
         @(negedge Clk);
         tests++; if (ser1 !== expLine(8'h3C, k)) begin fails++; $display("FAIL mid_re_ser k=%0d got %b exp %b", k, ser1, expLine(8'h3C, k)); end
         tests++; if (busy1 !== (k <= FL1)) begin fails++; $display("FAIL mid_re_busy k=%0d got %b exp %b", k, busy1, k <= FL1); end
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_two_stop_bits();
      TxData = 8'h81; req2 = 1'b1;
      @(negedge Clk);
      tests++; if (dl2 !== 1'b1) begin fails++; $display("FAIL stop2_dl0 got %b exp 1", dl2); end
      @(posedge Clk); #1;
      for (int k = 1; k <= FL2; k++) begin
         @(negedge Clk);
         tests++; if (ser2 !== expLine(8'h81, k)) begin fails++; $display("FAIL stop2_ser k=%0d got %b exp %b", k, ser2, expLine(8'h81, k)); end
         tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL stop2_busy k=%0d got %b exp 1", k, busy2); end
         tests++; if (dl2 !== (k == FL2)) begin fails++; $display("FAIL stop2_dl k=%0d got %b exp %b", k, dl2, k == FL2); end
         @(posedge Clk); #1;
         if (k == FL2) req2 = 1'b0;
      end
      repeat (FL2 + 2) begin @(posedge Clk); #1; end
      @(negedge Clk);
      tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL stop2_end_busy got %b exp 0", busy2); end
      tests++; if (ser2 !== 1'b1) begin fails++; $display("FAIL stop2_end_ser got %b exp 1", ser2); end
      @(posedge Clk); #1;
   endtask

   initial begin
      test_reset();
      test_frame(8'hA5);
      test_back_to_back();
      test_reset_mid_frame();
      test_two_stop_bits();
      test_frame(8'h07);
      test_frame(8'h03);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
